// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the fetch stage.
package core_pkg;
    typedef enum logic [1:0] {S_AR, S_R, S_OUT, S_WAIT} ifu_state_t;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
endpackage

// File: rtl/ifu_perf_cnt.sv
// ifu_perf_cnt: free-running 64-bit fetch and stall counters, cleared by rst.
module ifu_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_inc,
    input  logic        stall_inc,
    output logic [63:0] fetch_cnt,
    output logic [63:0] stall_cnt
);
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            fetch_cnt <= fetch_cnt + 64'(fetch_inc);
            stall_cnt <= stall_cnt + 64'(stall_inc);
        end
    end
endmodule

// File: rtl/ifu.sv
// ifu: single-outstanding AXI4-Lite instruction fetch feeding decode via valid/ready.
// Define IFU_PERF_EN to add the perf_fetch_cnt/perf_stall_cnt counters.
module ifu
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] ifu_araddr,
    output logic              ifu_arvalid,
    input  logic              ifu_arready,
    input  logic [DATA_W-1:0] ifu_rdata,
    input  logic [1:0]        ifu_rresp,
    input  logic              ifu_rvalid,
    output logic              ifu_rready,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] pc,
    output logic              this_valid,
    input  logic              next_ready,
    output logic              fetch_err,
    input  logic              npc_valid,
    input  logic [ADDR_W-1:0] npc
`ifdef IFU_PERF_EN
    ,
    output logic [63:0]       perf_fetch_cnt,
    output logic [63:0]       perf_stall_cnt
`endif
);
    ifu_state_t state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_AR;
            pc        <= ADDR_W'(RESET_PC);
            inst      <= '0;
            fetch_err <= 1'b0;
        end else begin
            case (state)
                S_AR: if (ifu_arready) state <= S_R;
                S_R: if (ifu_rvalid) begin
                    inst      <= ifu_rdata;
                    fetch_err <= ifu_rresp != RESP_OKAY;
                    state     <= S_OUT;
                end
                S_OUT: if (next_ready) begin
                    if (npc_valid) pc <= npc;
                    state <= npc_valid ? S_AR : S_WAIT;
                end
                S_WAIT: if (npc_valid) begin
                    pc    <= npc;
                    state <= S_AR;
                end
            endcase
        end
    end

    // Misaligned PCs are kept verbatim for decode to trap on; the bus only sees word addresses.
    assign ifu_araddr  = {pc[ADDR_W-1:2], 2'b00};
    assign ifu_arvalid = state == S_AR;
    assign ifu_rready  = state == S_R;
    assign this_valid  = state == S_OUT;

    npc_in_fetch: assert property (@(posedge clk) disable iff (rst)
        !(npc_valid && (state == S_AR || state == S_R)));

`ifdef IFU_PERF_EN
    ifu_perf_cnt u_perf (
        .clk       (clk),
        .rst       (rst),
        .fetch_inc (ifu_rvalid && ifu_rready),
        .stall_inc (state == S_AR || state == S_R),
        .fetch_cnt (perf_fetch_cnt),
        .stall_cnt (perf_stall_cnt)
    );
`endif
endmodule

// File: tb/tb_ifu.sv
// tb_ifu: directed and randomized fetches against a transaction-level PC/inst model.
module tb_ifu;
    import core_pkg::*;

    logic        clk = 0;
    logic        rst = 1;
    logic [31:0] ifu_araddr;
    logic        ifu_arvalid;
    logic        ifu_arready = 0;
    logic [31:0] ifu_rdata = 0;
    logic [1:0]  ifu_rresp = 0;
    logic        ifu_rvalid = 0;
    logic        ifu_rready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        this_valid;
    logic        next_ready = 0;
    logic        fetch_err;
    logic        npc_valid = 0;
    logic [31:0] npc = 0;
`ifdef IFU_PERF_EN
    logic [63:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    ifu dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .inst(inst), .pc(pc), .this_valid(this_valid), .next_ready(next_ready),
        .fetch_err(fetch_err), .npc_valid(npc_valid), .npc(npc)
`ifdef IFU_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          n_cmp = 0, n_fail = 0;
    logic [31:0] m_pc;
    longint      m_fetch, m_stall;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        rst = 1;
        tick;
        tick;
        chk("rst_arvalid", ifu_arvalid, 1);
        chk("rst_rready", ifu_rready, 0);
        chk("rst_valid", this_valid, 0);
        chk("rst_pc", pc, 32'h8000_0000);
        chk("rst_inst", inst, 0);
        chk("rst_err", fetch_err, 0);
        rst = 0;
        m_pc = 32'h8000_0000;
        m_fetch = 0;
        m_stall = 0;
    endtask

    // One full transaction: address phase, data phase, decode handoff, next-PC commit.
    task automatic fetch(input int ar_wait, input int r_wait, input logic [31:0] data,
                         input logic [1:0] resp, input int out_wait, input bit npc_same,
                         input logic [31:0] nxt, input int npc_delay);
        logic [31:0] a;
        a = {m_pc[31:2], 2'b00};
        chk("arvalid", ifu_arvalid, 1);
        chk("araddr", ifu_araddr, a);
        chk("pc_fetch", pc, m_pc);
        for (int i = 0; i < ar_wait; i++) begin
            tick;
            chk("arvalid_hold", ifu_arvalid, 1);
            chk("araddr_hold", ifu_araddr, a);
        end
        ifu_arready = 1;
        tick;
        ifu_arready = 0;
        chk("arvalid_drop", ifu_arvalid, 0);
        chk("rready", ifu_rready, 1);
        chk("valid_in_r", this_valid, 0);
        for (int i = 0; i < r_wait; i++) begin
            tick;
            chk("rready_hold", ifu_rready, 1);
        end
        ifu_rvalid = 1;
        ifu_rdata = data;
        ifu_rresp = resp;
        tick;
        ifu_rvalid = 0;
        ifu_rdata = $urandom;
        ifu_rresp = 2'($urandom);
        m_fetch++;
        m_stall += ar_wait + r_wait + 2;
        chk("this_valid", this_valid, 1);
        chk("inst", inst, data);
        chk("pc_out", pc, m_pc);
        chk("fetch_err", fetch_err, resp != 2'b00);
        chk("rready_out", ifu_rready, 0);
        for (int i = 0; i < out_wait; i++) begin
            tick;
            chk("hold_valid", this_valid, 1);
            chk("hold_inst", inst, data);
            chk("hold_pc", pc, m_pc);
            chk("hold_err", fetch_err, resp != 2'b00);
            chk("hold_no_ar", ifu_arvalid, 0);
        end
        next_ready = 1;
        npc_valid = npc_same;
        npc = nxt;
        tick;
        next_ready = 0;
        npc_valid = 0;
        m_pc = nxt;
        if (!npc_same) begin
            chk("wait_valid", this_valid, 0);
            chk("wait_no_ar", ifu_arvalid, 0);
            for (int i = 0; i < npc_delay; i++) begin
                tick;
                chk("wait_idle", ifu_arvalid, 0);
            end
            npc_valid = 1;
            npc = nxt;
            tick;
            npc_valid = 0;
        end
`ifdef IFU_PERF_EN
        chk("perf_fetch", perf_fetch_cnt, 64'(m_fetch));
        chk("perf_stall", perf_stall_cnt, 64'(m_stall));
`endif
    endtask

    initial begin
        do_reset;
        // Zero-wait memory: handshake cycle 0, data cycle 1, this_valid cycle 2.
        fetch(0, 0, 32'h0000_0413, 2'b00, 0, 0, 32'h8000_0004, 0);
        fetch(5, 0, 32'h1234_5678, 2'b00, 0, 0, 32'h8000_0008, 1);
        fetch(0, 1, 32'h0badf00d, 2'b00, 4, 1, 32'h8000_0010, 0);
        chk("npc_araddr", ifu_araddr, 32'h8000_0010);
        fetch(0, 0, 32'hDEAD_BEEF, 2'b10, 0, 0, 32'h8000_0016, 0);
        fetch(1, 0, 32'h0000_0013, 2'b00, 0, 0, 32'h8000_0020, 0);
        for (int k = 0; k < 40; k++) begin
            logic [1:0] resp;
            resp = ($urandom_range(3) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
            fetch($urandom_range(3), $urandom_range(3), $urandom, resp,
                  $urandom_range(2), 1'($urandom), $urandom, $urandom_range(2));
        end

        // Reset while waiting for read data; the stale rvalid lands in S_AR and is ignored.
        ifu_arready = 1;
        tick;
        ifu_arready = 0;
        chk("pre_rst_rready", ifu_rready, 1);
        ifu_rvalid = 1;
        ifu_rdata = 32'hFFFF_FFFF;
        do_reset;
        chk("stale_rready", ifu_rready, 0);
        tick;
        m_stall = 1;
        chk("stale_arvalid", ifu_arvalid, 1);
        chk("stale_valid", this_valid, 0);
        chk("stale_araddr", ifu_araddr, 32'h8000_0000);
        ifu_rvalid = 0;
        fetch(0, 0, 32'h0000_0093, 2'b00, 0, 0, 32'h8000_0004, 0);

`ifdef IFU_PERF_EN
        do_reset;
        chk("perf_rst_fetch", perf_fetch_cnt, 0);
        chk("perf_rst_stall", perf_stall_cnt, 0);
        for (int k = 0; k < 3; k++)
            fetch(2, 0, $urandom, 2'b00, 0, 0, m_pc + 4, 0);
        chk("perf_fetch3", perf_fetch_cnt, 3);
        chk("perf_stall12", perf_stall_cnt, 12);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
